// File: rtl/mac_seq_ctrl_pkg.sv
// Shared constants for the MAC sequencer: operand/product widths,
// multiply-block mode codes and the sequencer state encoding.
package mac_seq_ctrl_pkg;

    localparam int MAC_MIN_WIDTH  = 8;
    localparam int MAC_INT_WIDTH  = 32;
    localparam int MAC_CONF_WIDTH = 2;

    localparam logic [MAC_CONF_WIDTH-1:0] MAC_SINGLE = 2'd0;
    localparam logic [MAC_CONF_WIDTH-1:0] MAC_DUAL   = 2'd1;
    localparam logic [MAC_CONF_WIDTH-1:0] MAC_QUAD   = 2'd2;

    typedef enum logic [1:0] {
        MAC_SEQ_IDLE,
        MAC_SEQ_RUN,
        MAC_SEQ_DRAIN,
        MAC_SEQ_DONE
    } seq_state_e;

    function automatic logic mode_legal(
        input logic [MAC_CONF_WIDTH-1:0] m
    );
        return (m == MAC_SINGLE) || (m == MAC_DUAL) || (m == MAC_QUAD);
    endfunction

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Bundle of the sequencer's descriptor, operand, multiply and result buses.
// slave: sequencer side; master: operand/result/multiply environment side.
interface mac_seq_ctrl_if
    import mac_seq_ctrl_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int ACC_W = MAC_INT_WIDTH + 8
) ();

    logic                      cfg_valid;
    logic                      cfg_ready;
    logic [MAC_CONF_WIDTH-1:0] cfg_mode;
    logic [CNT_W-1:0]          cfg_len;
    logic                      cfg_err;

    logic                      in_valid;
    logic                      in_ready;
    logic [MAC_MIN_WIDTH-1:0]  in_a0;
    logic [MAC_MIN_WIDTH-1:0]  in_a1;
    logic [MAC_MIN_WIDTH-1:0]  in_a2;
    logic [MAC_MIN_WIDTH-1:0]  in_a3;
    logic [MAC_MIN_WIDTH-1:0]  in_b;

    logic                      mult_en;
    logic [MAC_CONF_WIDTH-1:0] mult_cfg;
    logic [MAC_MIN_WIDTH-1:0]  mult_a0;
    logic [MAC_MIN_WIDTH-1:0]  mult_a1;
    logic [MAC_MIN_WIDTH-1:0]  mult_a2;
    logic [MAC_MIN_WIDTH-1:0]  mult_a3;
    logic [MAC_MIN_WIDTH-1:0]  mult_b1;
    logic [MAC_INT_WIDTH-1:0]  mult_c;

    logic                      out_valid;
    logic                      out_ready;
    logic [ACC_W-1:0]          out_acc;
    logic                      out_ovf;

    modport slave (
        input  cfg_valid, cfg_mode, cfg_len,
        input  in_valid, in_a0, in_a1, in_a2, in_a3, in_b,
        input  mult_c, out_ready,
        output cfg_ready, cfg_err, in_ready,
        output mult_en, mult_cfg,
        output mult_a0, mult_a1, mult_a2, mult_a3, mult_b1,
        output out_valid, out_acc, out_ovf
    );

    modport master (
        output cfg_valid, cfg_mode, cfg_len,
        output in_valid, in_a0, in_a1, in_a2, in_a3, in_b,
        output mult_c, out_ready,
        input  cfg_ready, cfg_err, in_ready,
        input  mult_en, mult_cfg,
        input  mult_a0, mult_a1, mult_a2, mult_a3, mult_b1,
        input  out_valid, out_acc, out_ovf
    );

endinterface

// File: rtl/mac_seq_ctrl_acc.sv
// Accumulator with sticky carry-out flag; clear wins over add.
// Ports: clk, rst (async low), clr_i, add_i, val_i -> acc_o, ovf_o.
module mac_seq_ctrl_acc #(
    parameter int IN_W  = 32,
    parameter int ACC_W = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             add_i,
    input  logic [IN_W-1:0]  val_i,
    output logic [ACC_W-1:0] acc_o,
    output logic             ovf_o
);

    logic [ACC_W-1:0] acc_q;
    logic             ovf_q;
    logic [ACC_W:0]   sum;

    assign sum = {1'b0, acc_q} + {{(ACC_W + 1 - IN_W){1'b0}}, val_i};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (clr_i) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (add_i) begin
            acc_q <= sum[ACC_W-1:0];
            ovf_q <= ovf_q | sum[ACC_W];
        end
    end

    assign acc_o = acc_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product job sequencer driving an external multiply block.
// Ports: clk, rst (async low), flush, busy, io (descriptor/beat/mult/result).
module mac_seq_ctrl
    import mac_seq_ctrl_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int ACC_W = MAC_INT_WIDTH + 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    output logic         busy,
    mac_seq_ctrl_if.slave io
);

    seq_state_e                     state_q, state_d;
    logic [CNT_W-1:0]               remain_q, remain_d;
    logic [MAC_CONF_WIDTH-1:0]      mode_q, mode_d;
    logic                           op_vld_q, op_vld_d;
    logic                           err_q, err_d;
    logic [3:0][MAC_MIN_WIDTH-1:0]  a_q, a_d;
    logic [MAC_MIN_WIDTH-1:0]       b_q, b_d;
    logic                           acc_clr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= MAC_SEQ_IDLE;
            remain_q <= '0;
            mode_q   <= '0;
            op_vld_q <= 1'b0;
            err_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            mode_q   <= mode_d;
            op_vld_q <= op_vld_d;
            err_q    <= err_d;
            a_q      <= a_d;
            b_q      <= b_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        mode_d   = mode_q;
        op_vld_d = 1'b0;
        err_d    = 1'b0;
        a_d      = a_q;
        b_d      = b_q;
        acc_clr  = 1'b0;
        if (flush) begin
            state_d = MAC_SEQ_IDLE;
            acc_clr = 1'b1;
        end else begin
            unique case (state_q)
                MAC_SEQ_IDLE: begin
                    if (io.cfg_valid) begin
                        if (mode_legal(io.cfg_mode)) begin
                            mode_d   = io.cfg_mode;
                            remain_d = io.cfg_len;
                            acc_clr  = 1'b1;
                            state_d  = (io.cfg_len == '0) ? MAC_SEQ_DONE
                                                          : MAC_SEQ_RUN;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                MAC_SEQ_RUN: begin
                    if (io.in_valid) begin
                        // Lanes the mode does not use are forced to zero.
                        a_d[0]   = (mode_q != MAC_SINGLE) ? io.in_a0 : '0;
                        a_d[1]   = io.in_a1;
                        a_d[2]   = (mode_q == MAC_QUAD) ? io.in_a2 : '0;
                        a_d[3]   = (mode_q == MAC_QUAD) ? io.in_a3 : '0;
                        b_d      = io.in_b;
                        op_vld_d = 1'b1;
                        remain_d = remain_q - CNT_W'(1);
                        if (remain_q == CNT_W'(1)) begin
                            state_d = MAC_SEQ_DRAIN;
                        end
                    end
                end
                MAC_SEQ_DRAIN: begin
                    state_d = MAC_SEQ_DONE;
                end
                MAC_SEQ_DONE: begin
                    if (io.out_ready) begin
                        state_d = MAC_SEQ_IDLE;
                    end
                end
                default: begin
                    state_d = MAC_SEQ_IDLE;
                end
            endcase
        end
    end

    mac_seq_ctrl_acc #(
        .IN_W  (MAC_INT_WIDTH),
        .ACC_W (ACC_W)
    ) u_acc (
        .clk   (clk),
        .rst   (rst),
        .clr_i (acc_clr),
        .add_i (op_vld_q),
        .val_i (io.mult_c),
        .acc_o (io.out_acc),
        .ovf_o (io.out_ovf)
    );

    assign io.cfg_ready = (state_q == MAC_SEQ_IDLE);
    assign io.in_ready  = (state_q == MAC_SEQ_RUN);
    assign io.out_valid = (state_q == MAC_SEQ_DONE);
    assign io.cfg_err   = err_q;
    assign io.mult_en   = op_vld_q;
    assign io.mult_cfg  = mode_q;
    assign io.mult_a0   = a_q[0];
    assign io.mult_a1   = a_q[1];
    assign io.mult_a2   = a_q[2];
    assign io.mult_a3   = a_q[3];
    assign io.mult_b1   = b_q;
    assign busy         = (state_q != MAC_SEQ_IDLE);

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Randomized self-checking bench for mac_seq_ctrl with a multiply-block stub
// and a sum-of-products reference model.
module tb_mac_seq_ctrl;
    import mac_seq_ctrl_pkg::*;

    localparam int TB_ACC_W = 36;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    logic busy;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    logic [7:0] ba0[256];
    logic [7:0] ba1[256];
    logic [7:0] ba2[256];
    logic [7:0] ba3[256];
    logic [7:0] bb[256];
    logic [39:0] exp_q[$];

    logic [TB_ACC_W-1:0] last_acc;
    logic                last_ovf;
    logic [TB_ACC_W-1:0] ref_acc;

    mac_seq_ctrl_if #(.CNT_W(8), .ACC_W(TB_ACC_W)) io ();

    mac_seq_ctrl #(.CNT_W(8), .ACC_W(TB_ACC_W)) dut (
        .clk   (clk),
        .rst   (rst_n),
        .flush (flush),
        .busy  (busy),
        .io    (io.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Packed-lane product: SINGLE = A1*B, DUAL/QUAD = sum of Ai*B << 8*i.
    function automatic logic [31:0] prod(
        input logic [1:0] m,
        input logic [7:0] a0, input logic [7:0] a1,
        input logic [7:0] a2, input logic [7:0] a3,
        input logic [7:0] b
    );
        logic [63:0] p;
        p = 64'd0;
        if (m == MAC_SINGLE) begin
            p = 64'(a1) * 64'(b);
        end else if (m == MAC_DUAL) begin
            p = 64'(a0) * 64'(b) + ((64'(a1) * 64'(b)) << 8);
        end else if (m == MAC_QUAD) begin
            p = 64'(a0) * 64'(b) + ((64'(a1) * 64'(b)) << 8)
              + ((64'(a2) * 64'(b)) << 16) + ((64'(a3) * 64'(b)) << 24);
        end
        return p[31:0];
    endfunction

    always_comb io.mult_c = prod(io.mult_cfg, io.mult_a0, io.mult_a1,
                                 io.mult_a2, io.mult_a3, io.mult_b1);

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && io.mult_en) begin
            if (exp_q.size() == 0) begin
                chk("lane_unexpected", 64'd1, 64'd0);
            end else begin
                chk("lanes", {io.mult_b1, io.mult_a3, io.mult_a2,
                              io.mult_a1, io.mult_a0}, exp_q.pop_front());
            end
        end
    end

    task automatic set_beat(input int i, input logic [7:0] a0,
                            input logic [7:0] a1, input logic [7:0] a2,
                            input logic [7:0] a3, input logic [7:0] b);
        ba0[i] = a0; ba1[i] = a1; ba2[i] = a2; ba3[i] = a3; bb[i] = b;
    endtask

    task automatic rand_beats(input int n);
        for (int i = 0; i < n; i++) begin
            set_beat(i, 8'($urandom), 8'($urandom), 8'($urandom),
                     8'($urandom), 8'($urandom));
        end
    endtask

    task automatic cfg_send(input logic [1:0] m, input logic [7:0] len,
                            output int t);
        io.cfg_mode  = m;
        io.cfg_len   = len;
        io.cfg_valid = 1'b1;
        @(negedge clk);
        t = cyc;
        chk("cfg_ready", io.cfg_ready, 1);
        @(posedge clk); #1;
        io.cfg_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [1:0] m, input int i, output int t);
        logic [7:0] a0m, a2m, a3m;
        a0m = (m == MAC_SINGLE) ? 8'd0 : ba0[i];
        a2m = (m == MAC_QUAD) ? ba2[i] : 8'd0;
        a3m = (m == MAC_QUAD) ? ba3[i] : 8'd0;
        io.in_a0 = ba0[i]; io.in_a1 = ba1[i]; io.in_a2 = ba2[i];
        io.in_a3 = ba3[i]; io.in_b = bb[i];
        io.in_valid = 1'b1;
        t = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (io.in_ready) break;
        end
        if (!io.in_ready) begin
            chk("beat_timeout", 0, 1);
        end else begin
            t = cyc;
            exp_q.push_back({bb[i], a3m, a2m, ba1[i], a0m});
        end
        @(posedge clk); #1;
        io.in_valid = 1'b0;
    endtask

    task automatic run_job(input logic [1:0] m, input int n,
                           input int bub_at, input int bub_len, input int bp);
        logic [63:0] sum;
        int t_cfg, t_last, t_out, k, extra;
        sum = 64'd0;
        for (int i = 0; i < n; i++) begin
            sum += 64'(prod(m, ba0[i], ba1[i], ba2[i], ba3[i], bb[i]));
        end
        ref_acc = sum[TB_ACC_W-1:0];
        extra = (bub_at < n) ? bub_len : 0;
        cfg_send(m, n[7:0], t_cfg);
        t_last = t_cfg;
        for (int i = 0; i < n; i++) begin
            if (i == bub_at) begin
                repeat (bub_len) begin @(posedge clk); #1; end
            end
            send_beat(m, i, t_last);
        end
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!io.out_valid && k < 300);
        if (!io.out_valid) begin
            chk("out_timeout", 0, 1);
            return;
        end
        t_out = cyc;
        if (n > 0) chk("lat_last_beat", 64'(t_out - t_last), 2);
        chk("job_cycles", 64'(t_out - t_cfg),
            (n == 0) ? 64'd1 : 64'(n + 2 + extra));
        chk("acc", io.out_acc, 64'(ref_acc));
        chk("ovf", io.out_ovf, 64'((sum >> TB_ACC_W) != 0));
        chk("done_flags", {busy, io.in_ready, io.cfg_ready}, 3'b100);
        last_acc = io.out_acc;
        last_ovf = io.out_ovf;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk("bp_hold", {io.out_valid, io.out_acc},
                {1'b1, ref_acc});
        end
        io.out_ready = 1'b1;
        @(posedge clk); #1;
        io.out_ready = 1'b0;
        @(negedge clk);
        chk("after_accept", {io.out_valid, busy, io.cfg_ready}, 3'b001);
        chk("lane_q_empty", 64'(exp_q.size()), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int t;
        logic [TB_ACC_W-1:0] acc_nb;
        rst_n = 1'b0; flush = 1'b0;
        io.cfg_valid = 1'b0; io.cfg_mode = '0; io.cfg_len = '0;
        io.in_valid = 1'b0; io.in_a0 = '0; io.in_a1 = '0; io.in_a2 = '0;
        io.in_a3 = '0; io.in_b = '0; io.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cfg_ready", io.cfg_ready, 1);
        chk("rst_flags", {io.in_ready, io.cfg_err, io.out_valid, busy,
                          io.mult_en, io.out_ovf}, 0);
        chk("rst_acc", io.out_acc, 0);
        chk("rst_mult", {io.mult_cfg, io.mult_a0, io.mult_a1, io.mult_a2,
                         io.mult_a3, io.mult_b1}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        set_beat(0, 0, 2, 0, 0, 5);
        set_beat(1, 0, 3, 0, 0, 5);
        set_beat(2, 0, 4, 0, 0, 5);
        run_job(MAC_SINGLE, 3, 99, 0, 0);
        chk("single_45", last_acc, 45);

        set_beat(0, 8'h01, 8'h02, 8'h55, 8'h66, 8'h03);
        set_beat(1, 8'h01, 8'h02, 8'h77, 8'h88, 8'h03);
        run_job(MAC_DUAL, 2, 99, 0, 0);
        chk("dual_c06", last_acc, 64'h0C06);

        set_beat(0, 1, 2, 3, 4, 2);
        run_job(MAC_QUAD, 1, 99, 0, 0);
        chk("quad_sum", last_acc, 64'h08060402);

        rand_beats(4);
        run_job(MAC_QUAD, 4, 99, 0, 0);
        acc_nb = last_acc;
        run_job(MAC_QUAD, 4, 2, 3, 0);
        chk("bubble_same_sum", last_acc, 64'(acc_nb));

        io.cfg_mode = 2'd3; io.cfg_len = 8'd5; io.cfg_valid = 1'b1;
        @(posedge clk); #1;
        io.cfg_valid = 1'b0;
        @(negedge clk);
        chk("ill_err_pulse", {io.cfg_err, busy}, 2'b10);
        @(negedge clk);
        chk("ill_err_end", {io.cfg_err, busy}, 2'b00);
        @(posedge clk); #1;
        set_beat(0, 0, 7, 0, 0, 7);
        run_job(MAC_SINGLE, 1, 99, 0, 0);
        chk("single_49", last_acc, 49);

        run_job(MAC_DUAL, 0, 99, 0, 0);
        chk("len0_acc", last_acc, 0);

        rand_beats(3);
        run_job(MAC_QUAD, 3, 99, 0, 5);

        rand_beats(3);
        cfg_send(MAC_SINGLE, 8'd3, t);
        send_beat(MAC_SINGLE, 0, t);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_flags", {busy, io.cfg_ready, io.mult_en, io.out_valid},
            4'b0100);
        chk("rst_mid_acc", io.out_acc, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("rst_mid_noresult", {io.out_valid, busy}, 0);
        end
        @(posedge clk); #1;

        io.cfg_mode = MAC_SINGLE; io.cfg_len = 8'd2;
        io.cfg_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        io.cfg_valid = 1'b0; flush = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("flush_cfg_idle", {busy, io.cfg_ready, io.in_ready}, 3'b010);
        end
        @(posedge clk); #1;

        rand_beats(5);
        cfg_send(MAC_QUAD, 8'd5, t);
        send_beat(MAC_QUAD, 0, t);
        send_beat(MAC_QUAD, 1, t);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_run_flags", {busy, io.out_valid, io.mult_en, io.out_ovf},
            0);
        chk("flush_run_acc", io.out_acc, 0);
        chk("flush_lane_q", 64'(exp_q.size()), 0);
        @(posedge clk); #1;
        rand_beats(4);
        run_job(MAC_DUAL, 4, 99, 0, 1);

        for (int i = 0; i < 40; i++) set_beat(i, 8'hFF, 8'hFF, 8'hFF,
                                              8'hFF, 8'hFF);
        run_job(MAC_QUAD, 40, 99, 0, 0);
        chk("ovf_set", last_ovf, 1);
        set_beat(0, 0, 1, 0, 0, 1);
        run_job(MAC_SINGLE, 1, 99, 0, 0);
        chk("ovf_cleared", last_ovf, 0);

        for (int j = 0; j < 40; j++) begin
            int m, n, ba, bl, bp;
            m  = $urandom_range(0, 2);
            n  = $urandom_range(0, 12);
            ba = $urandom_range(0, n);
            bl = $urandom_range(0, 3);
            bp = $urandom_range(0, 3);
            rand_beats(n);
            run_job(m[1:0], n, ba, bl, bp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
